// File: rtl/Mesh.sv
// Shared mesh-router definitions: port count, port index constants and
// the output arbiter state type.
package Mesh;

   localparam int NUM_PORTS = 5;

   localparam int PORT_S = 0;
   localparam int PORT_W = 1;
   localparam int PORT_N = 2;
   localparam int PORT_E = 3;
   localparam int PORT_C = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Index following idx, wrapping back to 0 after n-1.
   function automatic int next_port(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic first-one finder: first set bit of req at or after ptr, wrapping
// from WIDTH-1 to 0. Outputs are all zero when req is empty.
module rr_pick #(
   parameter  int WIDTH = 5,
   localparam int IW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [WIDTH-1:0] onehot,
   output logic [IW-1:0]    index
);

   // Scan offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      int pos;
      pos    = 0;
      onehot = '0;
      index  = '0;
      for (int k = WIDTH - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= WIDTH) pos = pos - WIDTH;
         if (req[pos]) begin
            onehot      = '0;
            onehot[pos] = 1'b1;
            index       = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/output_port_arbiter.sv
// Wormhole output-port arbiter: round-robin choice among requesters in
// IDLE, then the output stays locked to that owner until its tail flit
// transfers. Optional packet counter enabled by OUTPUT_PORT_ARBITER_PKT_COUNT_EN.
module output_port_arbiter
   import Mesh::*;
#(
   parameter  int WIDTH = NUM_PORTS,
   localparam int IW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] req,
   input  logic [WIDTH-1:0] tail,
   input  logic             out_ready,
   output logic [WIDTH-1:0] grant,
   output logic [IW-1:0]    sel,
   output logic             out_valid,
   output logic             busy
`ifdef OUTPUT_PORT_ARBITER_PKT_COUNT_EN
   ,
   output logic [15:0]      pkt_count
`endif
);

   arb_state_t       state_q, state_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0] grant_q, grant_d;
   logic [WIDTH-1:0] pick_onehot;
   logic [IW-1:0]    pick_index;
   logic             locked;
   logic             xfer;
   logic             tail_xfer;

   rr_pick #(.WIDTH(WIDTH)) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .onehot (pick_onehot),
      .index  (pick_index)
   );

   // Transfer qualification; out_ready only ever feeds next-state logic.
   always_comb begin
      locked    = (state_q == LOCKED);
      xfer      = locked && req[owner_q] && out_ready;
      tail_xfer = xfer && tail[owner_q];
   end

   // Next state: lock onto the picked requester, release only on a tail transfer.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = LOCKED;
               owner_d = pick_index;
               grant_d = pick_onehot;
            end
         end
         LOCKED: begin
            if (tail_xfer) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = IW'(next_port(int'(owner_q), WIDTH));
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
      end
   end

   // Outputs come from state plus the owner's req; nothing from out_ready.
   always_comb begin
      grant     = grant_q;
      sel       = owner_q;
      busy      = locked;
      out_valid = locked && req[owner_q];
   end

`ifdef OUTPUT_PORT_ARBITER_PKT_COUNT_EN
   logic [15:0] pkt_count_q, pkt_count_d;

   // Count completed packets; wraps naturally at 16 bits.
   always_comb begin
      pkt_count_d = pkt_count_q;
      if (tail_xfer) pkt_count_d = pkt_count_q + 16'd1;
   end

   // Packet counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pkt_count_q <= '0;
      else        pkt_count_q <= pkt_count_d;
   end

   assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed table-driven bench for output_port_arbiter, plus hand-written
// reset sequences.
module tb_output_port_arbiter;
   import Mesh::*;

   localparam int W  = NUM_PORTS;
   localparam int IW = $clog2(W);
   localparam int NV = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  req = '0;
   logic [W-1:0]  tail = '0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  grant;
   logic [IW-1:0] sel;
   logic          out_valid;
   logic          busy;
`ifdef OUTPUT_PORT_ARBITER_PKT_COUNT_EN
   logic [15:0]   pkt_count;
`endif

   output_port_arbiter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .tail      (tail),
      .out_ready (out_ready),
      .grant     (grant),
      .sel       (sel),
      .out_valid (out_valid),
      .busy      (busy)
`ifdef OUTPUT_PORT_ARBITER_PKT_COUNT_EN
      ,
      .pkt_count (pkt_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]  req;
      logic [W-1:0]  tail;
      logic          rdy;
      logic [W-1:0]  g;
      logic [IW-1:0] s;
      logic          v;
      logic          b;
   } vec_t;

   vec_t tbl[NV];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [W-1:0] r, input logic [W-1:0] t, input logic rdy,
                               input logic [W-1:0] g, input int s, input logic v, input logic b);
      vec_t x;
      x.req = r; x.tail = t; x.rdy = rdy; x.g = g; x.s = IW'(s); x.v = v; x.b = b;
      return x;
   endfunction

   initial begin
      // single request on N, released after one flit (ptr -> 3)
      tbl[0]  = mk(5'b00100, 5'b00100, 1, 5'b00000, 0, 0, 0);
      tbl[1]  = mk(5'b00100, 5'b00100, 1, 5'b00100, 2, 1, 1);
      tbl[2]  = mk(5'b00000, 5'b00000, 1, 5'b00000, 2, 0, 0);
      // everyone requests single-flit packets: 3,4,0,1,2,3 with IDLE gaps
      tbl[3]  = mk(5'b11111, 5'b11111, 1, 5'b00000, 2, 0, 0);
      tbl[4]  = mk(5'b11111, 5'b11111, 1, 5'b01000, 3, 1, 1);
      tbl[5]  = mk(5'b11111, 5'b11111, 1, 5'b00000, 3, 0, 0);
      tbl[6]  = mk(5'b11111, 5'b11111, 1, 5'b10000, 4, 1, 1);
      tbl[7]  = mk(5'b11111, 5'b11111, 1, 5'b00000, 4, 0, 0);
      tbl[8]  = mk(5'b11111, 5'b11111, 1, 5'b00001, 0, 1, 1);
      tbl[9]  = mk(5'b11111, 5'b11111, 1, 5'b00000, 0, 0, 0);
      tbl[10] = mk(5'b11111, 5'b11111, 1, 5'b00010, 1, 1, 1);
      tbl[11] = mk(5'b11111, 5'b11111, 1, 5'b00000, 1, 0, 0);
      tbl[12] = mk(5'b11111, 5'b11111, 1, 5'b00100, 2, 1, 1);
      tbl[13] = mk(5'b11111, 5'b11111, 1, 5'b00000, 2, 0, 0);
      tbl[14] = mk(5'b11111, 5'b11111, 1, 5'b01000, 3, 1, 1);
      // wrap: ptr=4, req=00011 -> owner 0, then ptr=1 -> owner 1
      tbl[15] = mk(5'b00011, 5'b00011, 1, 5'b00000, 3, 0, 0);
      tbl[16] = mk(5'b00011, 5'b00011, 1, 5'b00001, 0, 1, 1);
      tbl[17] = mk(5'b00011, 5'b00011, 1, 5'b00000, 0, 0, 0);
      tbl[18] = mk(5'b00011, 5'b00011, 1, 5'b00010, 1, 1, 1);
      // 4-flit packet from W while all request; foreign tails ignored
      tbl[19] = mk(5'b00010, 5'b00000, 1, 5'b00000, 1, 0, 0);
      tbl[20] = mk(5'b11111, 5'b11101, 1, 5'b00010, 1, 1, 1);
      tbl[21] = mk(5'b11111, 5'b11101, 1, 5'b00010, 1, 1, 1);
      tbl[22] = mk(5'b11111, 5'b11101, 1, 5'b00010, 1, 1, 1);
      tbl[23] = mk(5'b11111, 5'b00010, 1, 5'b00010, 1, 1, 1);
      tbl[24] = mk(5'b11111, 5'b00000, 1, 5'b00000, 1, 0, 0);
      // owner N: 3 cycles backpressure, 2 bubble cycles, then tail
      tbl[25] = mk(5'b11111, 5'b11111, 0, 5'b00100, 2, 1, 1);
      tbl[26] = mk(5'b11111, 5'b11111, 0, 5'b00100, 2, 1, 1);
      tbl[27] = mk(5'b11111, 5'b11111, 0, 5'b00100, 2, 1, 1);
      tbl[28] = mk(5'b11011, 5'b11111, 1, 5'b00100, 2, 0, 1);
      tbl[29] = mk(5'b11011, 5'b11111, 1, 5'b00100, 2, 0, 1);
      tbl[30] = mk(5'b00100, 5'b00100, 1, 5'b00100, 2, 1, 1);
      tbl[31] = mk(5'b00000, 5'b00000, 1, 5'b00000, 2, 0, 0);

      // reset state
      #12;
      chk("reset grant", 32'(grant), 32'd0);
      chk("reset sel", 32'(sel), 32'd0);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
`ifdef OUTPUT_PORT_ARBITER_PKT_COUNT_EN
      chk("reset pkt_count", 32'(pkt_count), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         req       = tbl[i].req;
         tail      = tbl[i].tail;
         out_ready = tbl[i].rdy;
         @(negedge clk);
         chk($sformatf("v%0d grant", i), 32'(grant), 32'(tbl[i].g));
         chk($sformatf("v%0d sel", i), 32'(sel), 32'(tbl[i].s));
         chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].v));
         chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].b));
         @(posedge clk);
         #1;
      end
`ifdef OUTPUT_PORT_ARBITER_PKT_COUNT_EN
      chk("pkt_count after table", 32'(pkt_count), 32'd11);
`endif

      // reset in the middle of a packet owned by E (ptr is 3 here)
      req = 5'b01000; tail = 5'b00000; out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("lock E grant", 32'(grant), 32'b01000);
      chk("lock E busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst grant", 32'(grant), 32'd0);
      chk("async rst busy", 32'(busy), 32'd0);
      chk("async rst sel", 32'(sel), 32'd0);
      chk("async rst out_valid", 32'(out_valid), 32'd0);
`ifdef OUTPUT_PORT_ARBITER_PKT_COUNT_EN
      chk("async rst pkt_count", 32'(pkt_count), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post rst grant", 32'(grant), 32'b01000);
      chk("post rst sel", 32'(sel), 32'd3);
      chk("post rst out_valid", 32'(out_valid), 32'd1);
      tail = 5'b01000;
      @(posedge clk);
      #1;
      chk("post rst release grant", 32'(grant), 32'd0);
      chk("post rst release busy", 32'(busy), 32'd0);
`ifdef OUTPUT_PORT_ARBITER_PKT_COUNT_EN
      chk("post rst pkt_count", 32'(pkt_count), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
